// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word
// and the address wrap helper for the small instruction memory.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Keeps any byte address inside the power-of-two instruction memory.
    function automatic logic [31:0] wrap_addr(input logic [31:0] addr, input logic [31:0] mask);
        return addr & mask;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load captures a new word, squash clears only the
// valid bit, otherwise everything holds.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        squash,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr <= NOP;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_instr <= instr;
            if_id_pc    <= pc;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
        end else if (squash) begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the BOOT/RUN/HALT FSM, and feeds
// the IF/ID register with the word returned by the combinational imem.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          IMEM_BYTES = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic        halted
);

    localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc4_next;
    logic [31:0]  redirect_pc;
    logic         capture;
    logic         squash;

    always_comb begin
        pc4_next    = wrap_addr(pc + 32'd4, ADDR_MASK);
        redirect_pc = wrap_addr({redirect_target[31:2], 2'b00}, ADDR_MASK);
        capture     = (state == RUN) && !halt_req && !redirect && !stall;
        // Redirect beats stall, so the wrong-path word is dropped even while decode is stalled.
        squash      = (state != RUN) || halt_req || redirect;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'd0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (redirect) begin
                        pc <= redirect_pc;
                        if (redirect_target[1:0] != 2'b00)
                            misalign_err <= 1'b1;
                    end else if (!stall) begin
                        pc          <= pc4_next;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                HALT: state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

    assign imem_addr = pc;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (capture),
        .squash      (squash),
        .instr       (imem_data),
        .pc          (pc),
        .pc4         (pc4_next),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a 32-byte instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:7];

    fetch_stage #(.IMEM_BYTES(32), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem_data       (imem_data),
        .imem_addr       (imem_addr),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory, indexed by word.
    assign imem_data = mem[imem_addr[4:2]];

    // Drive inputs, then advance one rising edge and settle 1 time unit past it.
    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [31:0] tgt, input logic h);
        reset           = r;
        stall           = s;
        redirect        = rd;
        redirect_target = tgt;
        halt_req        = h;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " imem_addr"}, imem_addr, 32'h0);
        checkOutput({tag, " instr"}, if_id_instr, 32'h0);
        checkOutput({tag, " pc"}, if_id_pc, 32'h0);
        checkOutput({tag, " pc4"}, if_id_pc4, 32'h0);
        checkOutput({tag, " valid"}, 32'(if_id_valid), 32'h0);
        checkOutput({tag, " misalign"}, 32'(misalign_err), 32'h0);
        checkOutput({tag, " count"}, fetch_count, 32'h0);
        checkOutput({tag, " halted"}, 32'(halted), 32'h0);
    endtask

    initial begin
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h8C01_0004;
        mem[2] = 32'hAC02_0008;
        mem[3] = 32'h0022_1820;
        mem[4] = 32'h1063_FFFC;
        mem[5] = 32'h0800_0003;
        mem[6] = 32'h3C04_BEEF;
        mem[7] = 32'h0000_0013;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkReset("reset");

        // BOOT cycle: PC held, nothing valid yet
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("boot imem_addr", imem_addr, 32'h0);
        checkOutput("boot valid", 32'(if_id_valid), 32'h0);

        // First capture, 2 edges after reset release
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("first instr", if_id_instr, 32'h2008_0005);
        checkOutput("first pc", if_id_pc, 32'h0);
        checkOutput("first pc4", if_id_pc4, 32'h4);
        checkOutput("first valid", 32'(if_id_valid), 32'h1);
        checkOutput("first count", fetch_count, 32'd1);
        checkOutput("first imem_addr", imem_addr, 32'h4);

        // Free run through the end of memory and wrap back to 0
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("run%0d pc", k), if_id_pc, 32'((k * 4) % 32));
            checkOutput($sformatf("run%0d pc4", k), if_id_pc4, 32'(((k + 1) * 4) % 32));
            checkOutput($sformatf("run%0d instr", k), if_id_instr, mem[k % 8]);
            checkOutput($sformatf("run%0d count", k), fetch_count, 32'(k + 1));
        end
        checkOutput("wrap imem_addr", imem_addr, 32'h4);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre-stall pc", if_id_pc, 32'h4);
        checkOutput("pre-stall imem_addr", imem_addr, 32'h8);

        // Three stall cycles at pc=8
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("stall%0d imem_addr", k), imem_addr, 32'h8);
            checkOutput($sformatf("stall%0d pc", k), if_id_pc, 32'h4);
            checkOutput($sformatf("stall%0d instr", k), if_id_instr, 32'h8C01_0004);
            checkOutput($sformatf("stall%0d valid", k), 32'(if_id_valid), 32'h1);
            checkOutput($sformatf("stall%0d count", k), fetch_count, 32'd10);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("post-stall pc", if_id_pc, 32'h8);
        checkOutput("post-stall count", fetch_count, 32'd11);
        checkOutput("post-stall imem_addr", imem_addr, 32'hC);

        // Misaligned redirect together with stall
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0012, 1'b0);
        checkOutput("redir imem_addr", imem_addr, 32'h10);
        checkOutput("redir valid", 32'(if_id_valid), 32'h0);
        checkOutput("redir misalign", 32'(misalign_err), 32'h1);
        checkOutput("redir count", fetch_count, 32'd11);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("after redir pc", if_id_pc, 32'h10);
        checkOutput("after redir instr", if_id_instr, 32'h1063_FFFC);
        checkOutput("after redir valid", 32'(if_id_valid), 32'h1);
        checkOutput("misalign sticky", 32'(misalign_err), 32'h1);

        // Aligned redirect to 12, then halt there
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
        checkOutput("redir12 imem_addr", imem_addr, 32'hC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("halt halted", 32'(halted), 32'h1);
        checkOutput("halt imem_addr", imem_addr, 32'hC);
        checkOutput("halt valid", 32'(if_id_valid), 32'h0);
        checkOutput("halt pc held", if_id_pc, 32'h10);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b0);
            checkOutput($sformatf("halt redir%0d imem_addr", k), imem_addr, 32'hC);
            checkOutput($sformatf("halt redir%0d halted", k), 32'(halted), 32'h1);
            checkOutput($sformatf("halt redir%0d count", k), fetch_count, 32'd12);
        end

        // Reset leaves HALT
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkReset("halt exit");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("reboot valid", 32'(if_id_valid), 32'h0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rerun count", fetch_count, 32'd3);
        checkOutput("rerun imem_addr", imem_addr, 32'hC);

        // Reset dominates stall and redirect
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0013, 1'b0);
        checkReset("mid reset");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0018, 1'b0);
        checkOutput("boot ignores redir", imem_addr, 32'h0);
        checkOutput("boot ignores misalign", 32'(misalign_err), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("restart instr", if_id_instr, 32'h2008_0005);
        checkOutput("restart count", fetch_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that owns the program counter, drives the byte address into the combinational instruction memory and captures the returned 32-bit word into the IF/ID pipeline register. It handles sequential PC+4 advance, branch/jump redirect with wrong-path squash, decode-stage stall, a halt request and wrap-around of the small instruction memory. It sits between control/hazard logic (upstream) and the decode stage (downstream).

Parameters:
IMEM_BYTES, 32, instruction memory size in bytes; power of two, at least 4
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned and below IMEM_BYTES

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold the PC and IF/ID register (load-use hazard from decode)
redirect  in  1  branch or jump taken; load redirect_target
redirect_target  in  32  new PC byte address
halt_req  in  1  stop fetching until the next reset
imem_data  in  32  word returned by the instruction memory for imem_addr, same cycle
imem_addr  out  32  byte address to the instruction memory; always equals the PC register
if_id_instr  out  32  captured instruction
if_id_pc  out  32  PC of the captured instruction
if_id_pc4  out  32  if_id_pc + 4, wrapped
if_id_valid  out  1  captured instruction is on the correct path
misalign_err  out  1  sticky; a redirect_target had bits [1:0] nonzero
fetch_count  out  32  count of instructions captured with valid=1
halted  out  1  FSM is in HALT

Behaviour:
- Reset (synchronous, highest priority): pc=RESET_PC, if_id_instr=0 (NOP), if_id_pc=0, if_id_pc4=0, if_id_valid=0, misalign_err=0, fetch_count=0, state=BOOT, halted=0. Reset asserted mid-operation discards all in-flight state on that edge.
- FSM states:
  - BOOT: lasts exactly 1 cycle after reset deasserts. PC is held and if_id_valid stays 0. Always moves to RUN; stall, redirect and halt_req are ignored in this state.
  - RUN: normal fetch.
  - HALT: PC frozen, if_id_valid=0, IF/ID contents held, halted=1. Only reset leaves HALT.
- RUN edge priority, highest first:
  1. halt_req: go to HALT. if_id_valid<=0. PC unchanged.
  2. redirect: pc<=wrap({redirect_target[31:2],2'b00}). if_id_valid<=0 to squash the word fetched this cycle. Redirect overrides stall. If redirect_target[1:0]!=0, misalign_err<=1.
  3. stall: pc, if_id_instr, if_id_pc, if_id_pc4, if_id_valid and fetch_count all hold.
  4. Otherwise: if_id_instr<=imem_data, if_id_pc<=pc, if_id_pc4<=wrap(pc+4), if_id_valid<=1, pc<=wrap(pc+4), fetch_count+=1 (wraps at 2^32).
- wrap(x) = x mod IMEM_BYTES (mask with IMEM_BYTES-1). PC never leaves [0, IMEM_BYTES-4], so the memory is never indexed out of range. Sequential fetch after address IMEM_BYTES-4 returns to 0.
- Latency: a word presented on imem_addr in cycle n appears on if_id_instr after edge n+1. The first valid instruction appears 2 edges after reset deasserts (one BOOT cycle plus one capture).
- imem_data is used only on a capture edge; its value in any other cycle is don't-care.
- misalign_err clears only on reset.

Decomposition:
- Shared package fetch_pkg holds: the state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the NOP constant 32'h0000_0000 and the function wrap_addr.
- One sub-module, if_id_reg: the IF/ID pipeline register with load, hold and squash controls.
- PC, FSM and counter logic stay in fetch_stage.

Test Plan:
- Reset then free-run with memory bytes 0..3 = 20 08 00 05 -> after 2 edges if_id_instr=32'h2008_0005, if_id_pc=0, if_id_pc4=4, if_id_valid=1, fetch_count=1.
- 9 free-run captures with IMEM_BYTES=32 -> captured PCs are 0,4,...,28,0 in that order; the PC at address 28 yields if_id_pc4=0.
- Hold stall for 3 cycles at pc=8 -> imem_addr stays 8, IF/ID and fetch_count unchanged; one cycle after stall drops, if_id_pc=8.
- Assert redirect together with stall, redirect_target=32'h0000_0012 -> next pc=0x10, if_id_valid=0, misalign_err=1 and stays 1 until reset.
- Assert halt_req at pc=12 -> halted=1, imem_addr frozen at 12, if_id_valid=0, and later redirect pulses have no effect; assert reset -> pc=0, state BOOT, halted=0.
- Assert reset for 1 cycle while stall and redirect are active -> all outputs take their reset values on that edge.
